// File: rtl/simple_trace_pkg.sv
// Shared types and constants for the SIMPLE execution-trace transmitter.
//   TRACE_SYNC        - first byte of every frame, used by the host to find frame starts
//   TRACE_FRAME_BYTES - sync + 5 payload bytes + checksum
//   trace_rec_t       - one captured instruction record {pc, instr, szcv}
//   frame_state_e     - framer FSM states
//   tx_state_e        - UART byte transmitter FSM states
package simple_trace_pkg;

  localparam logic [7:0]  TRACE_SYNC        = 8'hA5;
  localparam int unsigned TRACE_FRAME_BYTES = 7;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [3:0]  szcv;
  } trace_rec_t;

  typedef enum logic [1:0] {FrIdle, FrLoad, FrSend, FrWait} frame_state_e;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // XOR of payload bytes 1..5 of a frame.
  function automatic logic [7:0] trace_checksum(input trace_rec_t rec);
    return rec.pc[15:8] ^ rec.pc[7:0] ^ rec.instr[15:8] ^ rec.instr[7:0] ^ {4'b0000, rec.szcv};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter.
//   clk, rst    - clock, synchronous active-high reset
//   byte_valid  - byte_data is offered for transmission
//   byte_data   - byte to send, LSB first
//   byte_ready  - a byte offered now is accepted at the next edge
//   txd         - registered serial output, idle high
module uart_tx_byte
  import simple_trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       txd
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            tick;

  assign tick = (cnt_q == CntMax);
  assign txd  = txd_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_ready = 1'b0;
    unique case (state_q)
      TxIdle: begin
        cnt_d      = '0;
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_d = TxStart;
          shift_d = byte_data;
        end
      end
      TxStart: begin
        if (tick) begin
          state_d = TxData;
          bit_d   = 3'd0;
        end
      end
      TxData: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = TxStop;
        end
      end
      TxStop: begin
        // Also ready in the last stop-bit cycle so a queued byte follows with no idle gap.
        if (tick) begin
          byte_ready = 1'b1;
          if (byte_valid) begin
            state_d = TxStart;
            shift_d = byte_data;
          end else begin
            state_d = TxIdle;
          end
        end
      end
      default: state_d = TxIdle;
    endcase

    // Output is registered from the next state so txd never glitches.
    case (state_d)
      TxStart: txd_d = 1'b0;
      TxData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TxIdle;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/simple_trace_tx.sv
// Execution-trace transmitter for the SIMPLE core: buffers retired-instruction records in a
// small FIFO and sends each as a 7-byte UART frame: A5, pc hi/lo, instr hi/lo, {0,szcv}, xor.
//   clk, rst      - clock, synchronous active-high reset
//   trace_valid   - one-cycle strobe qualifying trace_pc/trace_instr/trace_szcv
//   txd           - UART 8N1 output, idle high
//   busy          - FIFO non-empty or frame in flight
//   overflow      - sticky, set when a record is dropped on a full FIFO
//   dropped_count - dropped records, saturating at 255
module simple_trace_tx
  import simple_trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trace_valid,
  input  logic [15:0] trace_pc,
  input  logic [15:0] trace_instr,
  input  logic [3:0]  trace_szcv,
  output logic        txd,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  dropped_count
);

  localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam logic [2:0]  LastIdx = 3'(TRACE_FRAME_BYTES - 1);

  // FIFO
  trace_rec_t      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic            fifo_empty, fifo_full, push, drop, pop;
  trace_rec_t      fifo_head;
  logic            overflow_q;
  logic [7:0]      dropped_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                      (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  // Full is judged on registered pointers, so a same-cycle pop never frees a slot for a push.
  assign push       = trace_valid && !fifo_full;
  assign drop       = trace_valid && fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr_q[IdxW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mem[wr_ptr_q[IdxW-1:0]] <= '{pc: trace_pc, instr: trace_instr, szcv: trace_szcv};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= 8'h00;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (dropped_q != 8'hFF) dropped_q <= dropped_q + 8'h01;
      end
    end
  end

  // Framer
  frame_state_e state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  trace_rec_t   rec_q;
  logic [7:0]   csum_q;
  logic [7:0]   frame_byte;
  logic         byte_valid, byte_ready;
  logic [7:0]   byte_data;

  always_comb begin
    case (idx_q)
      3'd1:    frame_byte = rec_q.pc[15:8];
      3'd2:    frame_byte = rec_q.pc[7:0];
      3'd3:    frame_byte = rec_q.instr[15:8];
      3'd4:    frame_byte = rec_q.instr[7:0];
      3'd5:    frame_byte = {4'b0000, rec_q.szcv};
      3'd6:    frame_byte = csum_q;
      default: frame_byte = TRACE_SYNC;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pop        = 1'b0;
    byte_valid = 1'b0;
    byte_data  = frame_byte;
    unique case (state_q)
      FrIdle: begin
        if (!fifo_empty) state_d = FrLoad;
      end
      FrLoad: begin
        // The sync byte is constant, so it is offered while the record is latched; this keeps
        // the inter-frame gap to this single cycle.
        byte_valid = 1'b1;
        byte_data  = TRACE_SYNC;
        if (byte_ready) begin
          pop     = 1'b1;
          idx_d   = 3'd1;
          state_d = FrSend;
        end
      end
      FrSend: begin
        byte_valid = 1'b1;
        if (byte_ready) begin
          if (idx_q == LastIdx) state_d = FrWait;
          else                  idx_d   = idx_q + 3'd1;
        end
      end
      FrWait: begin
        // Ready again means the checksum byte's stop bit has completed.
        if (byte_ready) state_d = fifo_empty ? FrIdle : FrLoad;
      end
      default: state_d = FrIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FrIdle;
      idx_q   <= 3'd0;
      rec_q   <= '0;
      csum_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (pop) begin
        rec_q  <= fifo_head;
        csum_q <= trace_checksum(fifo_head);
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .txd       (txd)
  );

  assign busy          = !fifo_empty || (state_q != FrIdle);
  assign overflow      = overflow_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_simple_trace_tx.sv
module tb_simple_trace_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trace_valid = 1'b0;
  logic [15:0] trace_pc = 16'h0;
  logic [15:0] trace_instr = 16'h0;
  logic [3:0]  trace_szcv = 4'h0;
  logic        txd, busy, overflow;
  logic [7:0]  dropped_count;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];

  simple_trace_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trace_valid  (trace_valid),
    .trace_pc     (trace_pc),
    .trace_instr  (trace_instr),
    .trace_szcv   (trace_szcv),
    .txd          (txd),
    .busy         (busy),
    .overflow     (overflow),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART receiver: records each byte and the cycle its start bit began.
  initial begin
    logic [7:0] b;
    int t;
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        t = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = txd;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back(b);
        rx_t.push_back(t);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 100000", cyc);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    trace_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    rx_q.delete();
    rx_t.delete();
  endtask

  // One strobe; returns the cycle number of the sampling edge.
  task automatic strobe(input logic [15:0] pc, input logic [15:0] ins, input logic [3:0] f,
                        output int n);
    @(negedge clk);
    trace_pc = pc; trace_instr = ins; trace_szcv = f; trace_valid = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    trace_valid = 1'b0;
  endtask

  task automatic strobe_run(input int count, input int base);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      trace_pc = 16'(base + i); trace_instr = 16'(16'h1000 + base + i);
      trace_szcv = 4'(base + i); trace_valid = 1'b1;
    end
    @(negedge clk);
    trace_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin t = cyc; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow);
    else n_pass++;
    n_checks++;
    if (dropped_count !== 8'd0) $display("FAIL reset_dropped: got %0d want 0", dropped_count);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] exp_b [7] = '{8'hA5, 8'h00, 8'h12, 8'h8C, 8'h34, 8'h05, 8'hAF};
    int n, t;
    bit ok;
    strobe(16'h0012, 16'h8C34, 4'b0101, n);
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_rise: got %b want 1", busy);
    else n_pass++;
    wait_idle(400, t);
    n_checks++;
    if (t != n + 282) $display("FAIL single_busy_fall: got cycle %0d want %0d", t, n + 282);
    else n_pass++;
    wait_bytes(7, 10, ok);
    n_checks++; if (rx_q.size() != 7) $display("FAIL single_count: got %0d want 7", rx_q.size());
    else n_pass++;
    if (rx_q.size() == 7) begin
      n_checks++;
      if (rx_t[0] != n + 2) $display("FAIL single_latency: got %0d want %0d", rx_t[0], n + 2);
      else n_pass++;
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (rx_q[i] !== exp_b[i]) $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    int t;
    logic [7:0] cs;
    logic [7:0] e [7];
    do_reset();
    strobe_run(6, 1);
    n_checks++;
    if (dropped_count !== 8'd1) $display("FAIL ovf_dropped: got %0d want 1", dropped_count);
    else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow);
    else n_pass++;
    wait_idle(1700, t);
    repeat (60) @(negedge clk);
    n_checks++; if (rx_q.size() != 35) $display("FAIL ovf_count: got %0d want 35", rx_q.size());
    else n_pass++;
    if (rx_q.size() == 35) begin
      for (int f = 0; f < 5; f++) begin
        // Record k: pc=k, instr=0x1000+k, szcv=k; upper bytes are 00 and 10.
        cs = 8'(f + 1) ^ 8'h10 ^ 8'(f + 1) ^ 8'(f + 1);
        e = '{8'hA5, 8'h00, 8'(f + 1), 8'h10, 8'(f + 1), 8'(f + 1), cs};
        for (int i = 0; i < 7; i++) begin
          n_checks++;
          if (rx_q[f * 7 + i] !== e[i])
            $display("FAIL ovf_frame%0d_byte%0d: got %h want %h", f, i, rx_q[f * 7 + i], e[i]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    strobe_run(100, 1);
    n_checks++;
    if (dropped_count !== 8'd95) $display("FAIL sat_partial: got %0d want 95", dropped_count);
    else n_pass++;
    strobe_run(159, 101);
    n_checks++;
    if (dropped_count !== 8'd254) $display("FAIL sat_254: got %0d want 254", dropped_count);
    else n_pass++;
    strobe_run(1, 260);
    n_checks++;
    if (dropped_count !== 8'd255) $display("FAIL sat_255: got %0d want 255", dropped_count);
    else n_pass++;
    strobe_run(50, 261);
    n_checks++;
    if (dropped_count !== 8'd255) $display("FAIL sat_hold: got %0d want 255", dropped_count);
    else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL sat_overflow: got %b want 1", overflow);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp_b [7] = '{8'hA5, 8'h43, 8'h21, 8'hFA, 8'hCE, 8'h09, 8'h5F};
    int n, t;
    bit ok;
    do_reset();
    strobe_run(6, 1);
    // First strobe edge was 6 edges before now; byte 3 data bits span +126..+157.
    repeat (129) @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy);
    else n_pass++;
    rst = 1'b1;
    trace_valid = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (txd !== 1'b1) $display("FAIL mid_txd: got %b want 1", txd); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL mid_overflow: got %b want 0", overflow);
    else n_pass++;
    n_checks++;
    if (dropped_count !== 8'd0) $display("FAIL mid_dropped: got %0d want 0", dropped_count);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    trace_valid = 1'b0;
    repeat (60) @(negedge clk);
    rx_q.delete();
    rx_t.delete();
    strobe(16'h4321, 16'hFACE, 4'b1001, n);
    wait_bytes(7, 400, ok);
    wait_idle(100, t);
    repeat (60) @(negedge clk);
    n_checks++; if (rx_q.size() != 7) $display("FAIL mid_count: got %0d want 7", rx_q.size());
    else n_pass++;
    if (rx_q.size() == 7) begin
      n_checks++;
      if (rx_t[0] != n + 2) $display("FAIL mid_latency: got %0d want %0d", rx_t[0], n + 2);
      else n_pass++;
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (rx_q[i] !== exp_b[i]) $display("FAIL mid_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_idle();
    int bad_txd = 0;
    int bad_busy = 0;
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad_txd++;
      if (busy !== 1'b0) bad_busy++;
    end
    n_checks++; if (bad_txd != 0) $display("FAIL idle_txd: got %0d low cycles want 0", bad_txd);
    else n_pass++;
    n_checks++;
    if (bad_busy != 0) $display("FAIL idle_busy: got %0d busy cycles want 0", bad_busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [14] = '{8'hA5, 8'h01, 8'h00, 8'h23, 8'h45, 8'h0C, 8'h6B,
                               8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h03, 8'h02};
    int n, n2, t;
    bit ok;
    do_reset();
    strobe(16'h0100, 16'h2345, 4'b1100, n);
    strobe(16'hFFFF, 16'h0001, 4'b0011, n2);
    wait_bytes(14, 700, ok);
    n_checks++; if (!ok) $display("FAIL b2b_count: got %0d want 14", rx_q.size()); else n_pass++;
    wait_idle(100, t);
    n_checks++;
    if (t != n + 563) $display("FAIL b2b_busy_fall: got cycle %0d want %0d", t, n + 563);
    else n_pass++;
    if (rx_q.size() >= 14) begin
      n_checks++;
      if (rx_t[0] != n + 2) $display("FAIL b2b_latency: got %0d want %0d", rx_t[0], n + 2);
      else n_pass++;
      n_checks++;
      if (rx_t[6] - rx_t[0] != 240)
        $display("FAIL b2b_intra_frame: got %0d want 240", rx_t[6] - rx_t[0]);
      else n_pass++;
      n_checks++;
      if (rx_t[7] - rx_t[6] != 41) $display("FAIL b2b_gap: got %0d want 41", rx_t[7] - rx_t[6]);
      else n_pass++;
      for (int i = 0; i < 14; i++) begin
        n_checks++;
        if (rx_q[i] !== exp_b[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_saturation();
    test_reset_mid_frame();
    test_idle();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
